// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file operation sequencer:
// default widths and the sequencer state encoding.
`timescale 1ns/1ps
package regfile_seq_pkg;

    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefAddrW = 3;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StOper,
        StResult,
        StWrite
    } state_e;

endpackage

// File: rtl/regfile_seq_if.sv
// Bundle of the request, register-file, ALU-operand and ALU-result signals of regfile_seq.
// The slave side is the sequencer; the master side is its environment.
`timescale 1ns/1ps
interface regfile_seq_if
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_a_add;
    logic [ADDR_W-1:0] req_b_add;
    logic [ADDR_W-1:0] req_d_add;

    logic [ADDR_W-1:0] A_add;
    logic [ADDR_W-1:0] B_add;
    logic [ADDR_W-1:0] D_add;
    logic [DATA_W-1:0] data_in;
    logic              write_enable;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport slave (
        input  req_valid, req_a_add, req_b_add, req_d_add,
        output req_ready,
        output A_add, B_add, D_add, data_in, write_enable,
        input  data_a, data_b,
        output op_valid, op_a, op_b,
        input  op_ready,
        input  res_valid, res_data,
        output res_ready
    );

    modport master (
        output req_valid, req_a_add, req_b_add, req_d_add,
        input  req_ready,
        input  A_add, B_add, D_add, data_in, write_enable,
        output data_a, data_b,
        input  op_valid, op_a, op_b,
        output op_ready,
        output res_valid, res_data,
        input  res_ready
    );

endinterface

// File: rtl/regfile_seq.sv
// Sequencer that reads two registers, hands them to an ALU, waits for the result and
// writes it back to the destination register (writes to r0 are suppressed).
`timescale 1ns/1ps
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_seq_if.slave  bus
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   a_add_q, a_add_d;
    logic [ADDR_W-1:0]   b_add_q, b_add_d;
    logic [ADDR_W-1:0]   d_add_q, d_add_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_add_q   <= '0;
            b_add_q   <= '0;
            d_add_q   <= '0;
            dest_q    <= '0;
            data_in_q <= '0;
            we_q      <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_add_q   <= a_add_d;
            b_add_q   <= b_add_d;
            d_add_q   <= d_add_d;
            dest_q    <= dest_d;
            data_in_q <= data_in_d;
            we_q      <= we_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_add_d   = a_add_q;
        b_add_d   = b_add_q;
        d_add_d   = d_add_q;
        dest_d    = dest_q;
        data_in_d = data_in_q;
        // Write strobe is a single-cycle pulse that only the RESULT->WRITE edge raises.
        we_d      = 1'b0;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    a_add_d = bus.req_a_add;
                    b_add_d = bus.req_b_add;
                    dest_d  = bus.req_d_add;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                op_a_d  = bus.data_a;
                op_b_d  = bus.data_b;
                state_d = StOper;
            end
            StOper: begin
                if (bus.op_ready) begin
                    state_d = StResult;
                end
            end
            StResult: begin
                if (bus.res_valid) begin
                    d_add_d   = dest_q;
                    data_in_d = bus.res_data;
                    we_d      = (dest_q != '0);
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.req_ready    = (state_q == StIdle);
    assign bus.op_valid     = (state_q == StOper);
    assign bus.res_ready    = (state_q == StResult);
    assign bus.A_add        = a_add_q;
    assign bus.B_add        = b_add_q;
    assign bus.D_add        = d_add_q;
    assign bus.data_in      = data_in_q;
    assign bus.write_enable = we_q;
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq, paired with an 8x8 register file (r0 reads 0)
// whose read data appears one edge after the address.
`timescale 1ns/1ps
module tb_regfile_seq;
    import regfile_seq_pkg::*;

    localparam int unsigned DW = DefDataW;
    localparam int unsigned AW = DefAddrW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register-file responder with a side preload port.
    logic [DW-1:0] rf [8];
    logic [DW-1:0] rd_a, rd_b;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (bus.write_enable && bus.D_add != '0) rf[bus.D_add] <= bus.data_in;
        rd_a <= (bus.A_add == '0) ? '0 : rf[bus.A_add];
        rd_b <= (bus.B_add == '0) ? '0 : rf[bus.B_add];
    end
    assign bus.data_a = rd_a;
    assign bus.data_b = rd_b;

    // Architectural model: what each register should hold.
    logic [DW-1:0] mdl [8];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] val);
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = addr;
        pre_data = val;
        @(posedge clk);
        #1 pre_we = 1'b0;
        mdl[addr] = (addr == '0) ? '0 : val;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, "write_enable", bus.write_enable, 0);
        chk(tag, "A_add", bus.A_add, 0);
        chk(tag, "B_add", bus.B_add, 0);
        chk(tag, "D_add", bus.D_add, 0);
        chk(tag, "data_in", bus.data_in, 0);
        chk(tag, "op_a", bus.op_a, 0);
        chk(tag, "op_b", bus.op_b, 0);
        chk(tag, "op_valid", bus.op_valid, 0);
        chk(tag, "res_ready", bus.res_ready, 0);
        chk(tag, "req_ready", bus.req_ready, 1);
    endtask

    // One full operation, entered and left at a falling edge.
    task automatic run_txn(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] d, input logic [DW-1:0] res, input int stall,
                           input int rwait, input bit glitch, input logic [DW-1:0] exp_a,
                           input logic [DW-1:0] exp_b, input bit exp_we, input bit rst_in_write);
        int edges;
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk(tag, "req_ready idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_a_add = a;
        bus.req_b_add = b;
        bus.req_d_add = d;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a_add = AW'($urandom);
        bus.req_b_add = AW'($urandom);
        bus.req_d_add = AW'($urandom);
        chk(tag, "A_add", bus.A_add, a);
        chk(tag, "B_add", bus.B_add, b);
        chk(tag, "req_ready fetch", bus.req_ready, 0);
        if (glitch) begin
            bus.res_valid = 1'b1;
            bus.res_data = ~res;
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.op_ready = (stall == 0);
        chk(tag, "op_valid load", bus.op_valid, 0);
        @(posedge clk);
        edges++;
        @(negedge clk);
        chk(tag, "op_valid oper", bus.op_valid, 1);
        chk(tag, "op_a", bus.op_a, exp_a);
        chk(tag, "op_b", bus.op_b, exp_b);
        if (glitch) begin
            bus.res_valid = 1'b1;
            bus.res_data = ~res;
        end
        for (int i = 0; i < stall; i++) begin
            bus.op_ready = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
            chk(tag, "op_valid stall", bus.op_valid, 1);
            chk(tag, "op_a stall", bus.op_a, exp_a);
            chk(tag, "op_b stall", bus.op_b, exp_b);
            chk(tag, "res_ready stall", bus.res_ready, 0);
        end
        bus.op_ready = 1'b1;
        @(posedge clk);
        edges++;
        @(negedge clk);
        bus.op_ready = 1'b0;
        bus.res_valid = 1'b0;
        chk(tag, "op_valid result", bus.op_valid, 0);
        chk(tag, "res_ready", bus.res_ready, 1);
        for (int i = 0; i < rwait; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            chk(tag, "res_ready wait", bus.res_ready, 1);
            chk(tag, "write_enable wait", bus.write_enable, 0);
        end
        bus.res_valid = 1'b1;
        bus.res_data = res;
        @(posedge clk);
        edges++;
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.res_data = ~res;
        chk(tag, "write_enable", bus.write_enable, exp_we);
        chk(tag, "D_add", bus.D_add, d);
        chk(tag, "data_in", bus.data_in, res);
        chk(tag, "latency edges", edges, 5 + stall + rwait);
        chk(tag, "res_ready write", bus.res_ready, 0);
        if (rst_in_write) begin
            #2 rst_n = 1'b0;
            #1;
            chk_reset_outputs({tag, " async"});
            @(posedge clk);
            #1;
            chk(tag, "rf unchanged", rf[d], mdl[d]);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk(tag, "write_enable end", bus.write_enable, 0);
            chk(tag, "req_ready end", bus.req_ready, 1);
            if (d != '0) mdl[d] = res;
            chk(tag, "rf dest", rf[d], mdl[d]);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a, b, d;
        logic [DW-1:0] res;
        int            stall;
        int            rwait;
        bit            glitch;
        logic [DW-1:0] exp_a, exp_b;
        bit            exp_we;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{3'd3, 3'd5, 3'd6, 8'h46, 0, 0, 1'b0, 8'h12, 8'h34, 1'b1};
        vecs[1] = '{3'd6, 3'd3, 3'd0, 8'hFF, 0, 0, 1'b0, 8'h46, 8'h12, 1'b0};
        vecs[2] = '{3'd0, 3'd6, 3'd1, 8'h5A, 4, 0, 1'b0, 8'h00, 8'h46, 1'b1};
        vecs[3] = '{3'd1, 3'd0, 3'd2, 8'hA5, 0, 1, 1'b0, 8'h5A, 8'h00, 1'b1};
        vecs[4] = '{3'd2, 3'd2, 3'd7, 8'h3C, 0, 0, 1'b1, 8'hA5, 8'hA5, 1'b1};

        bus.req_valid = 1'b0;
        bus.req_a_add = '0;
        bus.req_b_add = '0;
        bus.req_d_add = '0;
        bus.op_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");

        for (int r = 0; r < 8; r++) begin
            preload(AW'(r), (r == 3) ? 8'h12 : (r == 5) ? 8'h34 : 8'h00);
        end
        @(negedge clk);
        chk_reset_outputs("reset held");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].res,
                    vecs[i].stall, vecs[i].rwait, vecs[i].glitch, vecs[i].exp_a,
                    vecs[i].exp_b, vecs[i].exp_we, 1'b0);
        end
        chk("vec1", "r0 reads zero", rf[0], 0);

        // Reset during WRITE abandons the write; first request accepted right after release.
        run_txn("rst_write", 3'd7, 3'd3, 3'd4, 8'h77, 0, 0, 1'b0, mdl[7], mdl[3], 1'b1, 1'b1);
        run_txn("post_rst", 3'd4, 3'd7, 3'd5, 8'h11, 0, 0, 1'b0, mdl[4], mdl[7], 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] ra, rb, rd;
            logic [DW-1:0] rr;
            ra = AW'($urandom);
            rb = AW'($urandom);
            rd = AW'($urandom);
            rr = DW'($urandom);
            run_txn($sformatf("rnd%0d", n), ra, rb, rd, rr, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), mdl[ra], mdl[rb],
                    rd != '0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, 8, width of register data.
REQ-002 The block SHALL have parameter ADDR_W, 3, width of register addresses (8 registers).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req_valid  input  1  operation request valid.
REQ-006 Port req_ready  output  1  block able to accept a request.
REQ-007 Port req_a_add, req_b_add, req_d_add  input  ADDR_W each  source A, source B, destination register.
REQ-008 Port A_add, B_add, D_add  output  ADDR_W each  register-file read/write addresses, registered.
REQ-009 Port data_in  output  DATA_W  register-file write data, registered.
REQ-010 Port write_enable  output  1  register-file write strobe, registered.
REQ-011 Port data_a, data_b  input  DATA_W each  register-file read data; valid one clk edge after A_add/B_add change.
REQ-012 Port op_valid  output  1  operands valid toward the ALU.
REQ-013 Port op_ready  input  1  ALU accepts operands.
REQ-014 Port op_a, op_b  output  DATA_W each  captured operands.
REQ-015 Port res_valid  input  1  ALU result valid.
REQ-016 Port res_ready  output  1  block accepting a result.
REQ-017 Port res_data  input  DATA_W  ALU result.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, LOAD, OPER, RESULT, WRITE.
REQ-019 req_ready SHALL be 1 only in IDLE; res_ready SHALL be 1 only in RESULT; op_valid SHALL be 1 only in OPER.
REQ-020 IDLE with req_valid=1 SHALL, at that edge, latch req_a_add->A_add, req_b_add->B_add, req_d_add into an internal destination register, and go to FETCH.
REQ-021 FETCH SHALL last exactly one cycle, then go to LOAD; this cycle covers the register-file read latency.
REQ-022 LOAD SHALL capture data_a->op_a and data_b->op_b at its ending edge, then go to OPER.
REQ-023 OPER SHALL hold op_a/op_b stable and stay until op_valid&&op_ready, then go to RESULT; op_ready high before OPER completes the handshake in the first OPER cycle.
REQ-024 RESULT SHALL ignore res_valid outside RESULT; on res_valid=1 it SHALL load D_add=destination, data_in=res_data, write_enable=(destination!=0), and go to WRITE.
REQ-025 WRITE SHALL last one cycle; at its ending edge write_enable SHALL return to 0 and the state to IDLE.
REQ-026 A write to register 0 SHALL be suppressed: write_enable stays 0, and the sequence still completes through WRITE.
REQ-027 Minimum request-to-writeback latency SHALL be 5 edges: accept, FETCH, LOAD, OPER, RESULT with write_enable high during WRITE.
REQ-028 A request SHALL be accepted no earlier than the edge after WRITE, so a read following a write to the same register returns the new value without forwarding.
REQ-029 A_add, B_add and op_a/op_b SHALL hold their values in IDLE between requests.

Reset
REQ-030 On rst_n=0 the FSM SHALL enter IDLE asynchronously, and A_add, B_add, D_add, data_in, op_a, op_b SHALL be 0, write_enable 0, op_valid 0, res_ready 0, req_ready 1 after release.
REQ-031 Reset mid-operation, including in WRITE, SHALL abandon the operation with write_enable forced to 0 immediately.
REQ-032 The first request SHALL be accepted on the first edge after rst_n deasserts.

Structure
REQ-033 State encoding, DATA_W and ADDR_W defaults SHALL live in shared package regfile_seq_pkg.
REQ-034 No sub-module SHALL be used; the bench SHALL pair regfile_seq with the team's 8x8 register file (r0 reads 0) as the responder.

Verification
REQ-035 Preload r3=0x12, r5=0x34; request A=3, B=5, D=6; op_ready=1; res_data=0x46 on first RESULT cycle -> op_a=0x12, op_b=0x34; write_enable pulse with D_add=6, data_in=0x46, 5 edges after accept.
REQ-036 Request with D=0, res_data=0xFF -> write_enable stays 0; r0 still reads 0x00; block returns to IDLE.
REQ-037 Hold op_ready=0 for 4 cycles in OPER -> op_valid stays 1, op_a/op_b unchanged, no state advance until op_ready=1.
REQ-038 Back-to-back: write r2=0xA5, then immediate request A=2, B=2 -> op_a=op_b=0xA5.
REQ-039 Assert rst_n=0 during WRITE -> write_enable drops without a clock edge; all outputs at reset values; r-file contents unchanged after a dummy edge.
REQ-040 res_valid=1 pulsed during FETCH and OPER -> ignored; writeback uses only the res_data present in RESULT.
